// File: rtl/sync_fifo_thresh_pkg.sv
// Shared defaults and types for the parametrised synchronous FIFO family.
// The typedefs are sized for the default configuration. Modules that are
// built with other sizes declare matching local types from their own
// parameters.
package fifo_package;

    localparam int DEF_W_WIDTH = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_P_WIDTH = $clog2(DEF_DEPTH);

    // The pointer carries one extra wrap bit above the index bits.
    typedef logic [DEF_P_WIDTH:0]   ptr_t;
    // Fill level runs 0..DEPTH, so it also needs P_WIDTH+1 bits.
    typedef logic [DEF_P_WIDTH:0]   cnt_t;
    typedef logic [DEF_W_WIDTH-1:0] data_t;

endpackage

// File: rtl/sync_fifo_thresh_mem.sv
// fifo_mem: simple dual-port storage array for the FIFO.
// Writes are synchronous and reads are combinational. Any read register
// belongs to the wrapper, so that the same array can serve both the
// registered-read mode and the fall-through mode. Contents are not reset.
module fifo_mem #(
    parameter int W_WIDTH = 8,
    parameter int DEPTH   = 16,
    parameter int A_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [W_WIDTH-1:0] wdata,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [W_WIDTH-1:0] rdata
);

    logic [W_WIDTH-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh: single-clock FIFO with a fill count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro FIFO_FWFT_EN selects first-word fall-through. In that mode
// the head word is driven combinationally onto rd_data. Without the macro,
// rd_data is a register that is loaded on each accepted read.
module sync_fifo_thresh
    import fifo_package::*;
#(
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int P_WIDTH  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [W_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    output logic [W_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [P_WIDTH:0]   count,
    output logic               overflow,
    output logic               underflow,
    input  logic               err_clr
);

    localparam logic [P_WIDTH:0] DEPTH_C = DEPTH[P_WIDTH:0];
    localparam logic [P_WIDTH:0] AF_C    = AF_THRESH[P_WIDTH:0];
    localparam logic [P_WIDTH:0] AE_C    = AE_THRESH[P_WIDTH:0];

    logic [P_WIDTH:0]   wr_ptr, rd_ptr;
    logic [W_WIDTH-1:0] mem_rdata;
    logic               wr_acc, rd_acc;

    // Acceptance uses only the registered status. A read and a write in the
    // same cycle therefore never interact: a read does not make room for a
    // write when the FIFO is full, and a write does not satisfy a read when
    // it is empty.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Status flags are decoded from the registered count only, so they are
    // glitch-free.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    fifo_mem #(
        .W_WIDTH (W_WIDTH),
        .DEPTH   (DEPTH),
        .A_WIDTH (P_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[P_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[P_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Pointers advance only on accepted transfers and wrap modulo 2*DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Fill level: up on a write only, down on a read only, otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. When a new error and a clear arrive together, the
    // new error wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) overflow <= 1'b1;
            else if (err_clr)  overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (err_clr)   underflow <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    // The head word falls through. It is meaningful only while !empty.
    assign rd_data = mem_rdata;
`else
    logic [W_WIDTH-1:0] rd_data_q;

    // Registered read: the head is captured on the edge that accepts the read
    // and is then held until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem_rdata;
    end

    assign rd_data = rd_data_q;
`endif

endmodule
